// File: rtl/addsub_seq.sv
// addsub_seq: nibble-serial sequencer for a 4-bit add/sub unit.
// Presents one operand nibble pair per cycle (LSB first), chains the
// nibble carry and assembles the WIDTH-bit result plus flags.
// Optional feature: define ADDSUB_SEQ_OVF_EN to compute signed overflow;
// otherwise ovf is tied low.
module addsub_seq #(
  parameter  int NIBBLES = 4,
  localparam int WIDTH   = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             ovf,
  output logic [3:0]       as_a,
  output logic [3:0]       as_b,
  output logic             as_m,
  output logic             as_cin,
  input  logic [3:0]       as_s,
  input  logic             as_co
);

  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             mode_q, mode_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             as_m_q, as_m_d;

  logic             in_run;
  logic             last_nib;
  logic [3:0]       nib_a, nib_b;

  assign in_run   = (state_q == S_RUN);
  assign last_nib = (idx_q == IDXW'(NIBBLES - 1));

  // Select the operand nibbles addressed by the current index.
  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDXW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end else begin
        nib_a = nib_a;
        nib_b = nib_b;
      end
    end
  end

  // Drive the add/sub unit only while running; the first nibble takes mode as carry-in.
  always_comb begin
    if (in_run) begin
      as_a   = nib_a;
      as_b   = nib_b;
      as_cin = (idx_q == '0) ? mode_q : carry_q;
    end else begin
      as_a   = 4'h0;
      as_b   = 4'h0;
      as_cin = 1'b0;
    end
  end

  // Next-state logic: accept in IDLE, capture one nibble per RUN cycle, pulse in DONE.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    mode_d      = mode_q;
    carry_d     = carry_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          idx_d   = '0;
          a_d     = op_a;
          b_d     = op_b;
          mode_d  = mode;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IDXW'(i)) begin
            result_d[4*i +: 4] = as_s;
          end else begin
            result_d[4*i +: 4] = result_q[4*i +: 4];
          end
        end
        carry_d = as_co;
        if (last_nib) begin
          state_d     = S_DONE;
          idx_d       = '0;
          carry_out_d = as_co;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
    as_m_d = (state_d == S_RUN) ? mode_d : 1'b0;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= 1'b0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      as_m_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mode_q      <= mode_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      as_m_q      <= as_m_d;
    end
  end

`ifdef ADDSUB_SEQ_OVF_EN
  logic ovf_q, ovf_d;
  logic c3_s;

  // Carry into bit 3 of the top nibble, recovered from the sum bit and the effective inputs.
  assign c3_s = as_s[3] ^ as_a[3] ^ (as_b[3] ^ mode_q);

  // Signed overflow is the carry into the sign bit XOR the carry out of it.
  always_comb begin
    if (in_run && last_nib) begin
      ovf_d = c3_s ^ as_co;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign as_m      = as_m_q;

endmodule
